// File: rtl/seq_loader.sv
// seq_loader: assembles two coded nucleotide sequences into the NW core memories (optional drop counter: SEQ_LOADER_DROPCNT_EN)
module seq_loader #(
   parameter int MAX_LEN = 16,
   parameter int ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        char,
   input  logic              char_valid,
   input  logic              core_ack,
   output logic              mem_we_a,
   output logic              mem_we_b,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_data,
   output logic [ADDR_W:0]   len_a,
   output logic [ADDR_W:0]   len_b,
   output logic              seq_ready,
   output logic              overflow,
`ifdef SEQ_LOADER_DROPCNT_EN
   output logic [7:0]        drop_cnt,
`endif
   output logic              busy
);
   typedef enum logic [1:0] {LOAD_A, LOAD_B, READY, ERR} state_t;
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(MAX_LEN);
   state_t            state, state_n;
   logic [ADDR_W:0]   count, count_n, len_a_n, len_b_n;
   logic              we_a_n, we_b_n, ovf_n, load, full, nuc;
   logic [ADDR_W-1:0] addr_n;
   logic [2:0]        data_n;
   assign load = (state == LOAD_A) || (state == LOAD_B);
   assign full = count == FULL;
   assign nuc  = char != 3'b000;
   // next state and next registered outputs
   always_comb begin
      state_n = state;
      count_n = count;
      we_a_n  = 1'b0;
      we_b_n  = 1'b0;
      addr_n  = mem_addr;
      data_n  = mem_data;
      len_a_n = len_a;
      len_b_n = len_b;
      ovf_n   = overflow;
      if (load && char_valid && nuc) begin
         state_n = full ? ERR : state;
         ovf_n   = overflow | full;
         we_a_n  = !full && (state == LOAD_A);
         we_b_n  = !full && (state == LOAD_B);
         addr_n  = full ? mem_addr : count[ADDR_W-1:0];
         data_n  = full ? mem_data : char;
         count_n = full ? count : count + 1'b1;
      end else if (load && char_valid && count != '0) begin
         count_n = '0;
         len_a_n = (state == LOAD_A) ? count : len_a;
         len_b_n = (state == LOAD_B) ? count : len_b;
         state_n = (state == LOAD_A) ? LOAD_B : READY;
      end else if (state == READY && core_ack) begin
         state_n = LOAD_A;
         count_n = '0;
      end
   end
   // state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOAD_A;
         count     <= '0;
         mem_we_a  <= 1'b0;
         mem_we_b  <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         len_a     <= '0;
         len_b     <= '0;
         seq_ready <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         mem_we_a  <= we_a_n;
         mem_we_b  <= we_b_n;
         mem_addr  <= addr_n;
         mem_data  <= data_n;
         len_a     <= len_a_n;
         len_b     <= len_b_n;
         seq_ready <= state_n == READY;
         overflow  <= ovf_n;
         busy      <= (state_n == LOAD_B) || (state_n == LOAD_A && count_n != '0);
      end
   end
`ifdef SEQ_LOADER_DROPCNT_EN
   logic drop;
   assign drop = char_valid && (!load || (nuc ? full : count == '0));
   // saturating count of characters that were ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_seq_loader.sv
// tb_seq_loader: directed self-checking bench for seq_loader
module tb_seq_loader;
   logic       clk = 1'b0, rst = 1'b0, char_valid = 1'b0, core_ack = 1'b0;
   logic [2:0] char = 3'b000;
   logic       mem_we_a, mem_we_b, seq_ready, overflow, busy;
   logic [3:0] mem_addr;
   logic [2:0] mem_data;
   logic [4:0] len_a, len_b;
`ifdef SEQ_LOADER_DROPCNT_EN
   logic [7:0] drop_cnt;
`endif
   int errors = 0, checks = 0;
   localparam logic [2:0] A = 3'b100, C = 3'b110, G = 3'b001, T = 3'b011, D = 3'b000;

   seq_loader dut (
      .clk(clk), .rst(rst), .char(char), .char_valid(char_valid), .core_ack(core_ack),
      .mem_we_a(mem_we_a), .mem_we_b(mem_we_b), .mem_addr(mem_addr), .mem_data(mem_data),
      .len_a(len_a), .len_b(len_b), .seq_ready(seq_ready), .overflow(overflow),
`ifdef SEQ_LOADER_DROPCNT_EN
      .drop_cnt(drop_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drops(input int exp);
`ifdef SEQ_LOADER_DROPCNT_EN
      chk("drop_cnt", drop_cnt, exp);
`endif
   endtask

   task automatic strobe(input logic [2:0] c);
      @(negedge clk);
      char = c;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic wr(input string tag, input int a, input int b, input int addr, input int data);
      chk({tag, "_we_a"}, mem_we_a, a);
      chk({tag, "_we_b"}, mem_we_b, b);
      chk({tag, "_addr"}, mem_addr, addr);
      chk({tag, "_data"}, mem_data, data);
   endtask

   task automatic ack();
      @(negedge clk);
      core_ack = 1'b1;
      @(negedge clk);
      core_ack = 1'b0;
      chk("ack_ready", seq_ready, 0);
   endtask

   task automatic zeros(input string tag);
      chk({tag, "_we"}, {mem_we_a, mem_we_b}, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_data"}, mem_data, 0);
      chk({tag, "_len"}, {len_a, len_b}, 0);
      chk({tag, "_flags"}, {seq_ready, overflow, busy}, 0);
      drops(0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      zeros("reset");
      rst = 1'b1;
      // basic load with strobes two clocks apart
      strobe(A); wr("t1_a0", 1, 0, 0, 4); chk("t1_busy", busy, 1);
      @(negedge clk); chk("t1_pulse", mem_we_a, 0);
      strobe(C); wr("t1_a1", 1, 0, 1, 6); @(negedge clk);
      strobe(G); wr("t1_a2", 1, 0, 2, 1); @(negedge clk);
      strobe(D); chk("t1_len_a", len_a, 3); chk("t1_nowr", {mem_we_a, mem_we_b}, 0); @(negedge clk);
      strobe(T); wr("t1_b0", 0, 1, 0, 3); @(negedge clk);
      strobe(T); wr("t1_b1", 0, 1, 1, 3); @(negedge clk);
      strobe(D); chk("t1_len_b", len_b, 2); chk("t1_ready", seq_ready, 1); chk("t1_busy_rdy", busy, 0);
      ack(); chk("t1_len_a_kept", len_a, 3);
      // leading and repeated delimiters
      strobe(D); strobe(D); chk("t2_skip", {mem_we_a, busy}, 0);
      strobe(G); wr("t2_a0", 1, 0, 0, 1);
      strobe(D); strobe(D); chk("t2_skip_b", mem_we_b, 0);
      strobe(C); wr("t2_b0", 0, 1, 0, 6);
      strobe(D);
      chk("t2_len_a", len_a, 1); chk("t2_len_b", len_b, 1);
      chk("t2_ready", seq_ready, 1); chk("t2_ovf", overflow, 0);
      drops(3);
      ack();
      // 17 back-to-back characters overflow sequence A
      @(negedge clk);
      char = A;
      char_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("t3_we_%0d", i), mem_we_a, 1);
         chk($sformatf("t3_addr_%0d", i), mem_addr, i);
      end
      @(negedge clk);
      char_valid = 1'b0;
      chk("t3_17_we", mem_we_a, 0); chk("t3_ovf", overflow, 1);
      chk("t3_err_flags", {seq_ready, busy}, 0);
      strobe(C); chk("t3_err_nowr", {mem_we_a, mem_we_b}, 0); chk("t3_ovf_sticky", overflow, 1);
      drops(5);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); zeros("t3_rst");
      rst = 1'b1;
      // characters while ready are dropped until ack
      strobe(A); strobe(D); strobe(C); strobe(D);
      chk("t4_ready", seq_ready, 1);
      strobe(G); chk("t4_g_nowr", {mem_we_a, mem_we_b}, 0);
      strobe(T); chk("t4_t_nowr", {mem_we_a, mem_we_b}, 0);
      chk("t4_ready_hold", seq_ready, 1); chk("t4_lens", {len_a, len_b}, {5'd1, 5'd1});
      drops(2);
      @(negedge clk);
      core_ack = 1'b1; char = C; char_valid = 1'b1;
      @(negedge clk);
      core_ack = 1'b0; char_valid = 1'b0;
      chk("t4_ack_ready", seq_ready, 0); chk("t4_ack_nowr", mem_we_a, 0); chk("t4_ack_busy", busy, 0);
      drops(3);
      strobe(G); wr("t4_restart", 1, 0, 0, 1);
      // asynchronous reset in the middle of sequence B
      strobe(D);
      strobe(A); strobe(T); strobe(G); strobe(C); strobe(A);
      wr("t5_b4", 0, 1, 4, 4);
      @(posedge clk); #2 rst = 1'b0;
      #1 zeros("t5_async");
      @(negedge clk); rst = 1'b1;
      strobe(C); wr("t5_a0", 1, 0, 0, 6);
      strobe(D); strobe(A); wr("t5_b0", 0, 1, 0, 4);
      strobe(D);
      chk("t5_lens", {len_a, len_b}, {5'd1, 5'd1}); chk("t5_ready", seq_ready, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
